// File: rtl/lzrw1_group_packer.sv
// LZRW1 group writer: packs literal/copy items into groups and serializes control word + item bytes.
// Optional statistics counters are built only when LZRW1_PACK_STATS_EN is defined.
module lzrw1_group_packer #(
  parameter int unsigned GROUP_ITEMS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic        tok_is_copy,
  input  logic [15:0] tok_data,
  input  logic        tok_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        packer_busy,
  output logic [31:0] stat_items,
  output logic [31:0] stat_bytes
);

  localparam int unsigned CTRL_BYTES = GROUP_ITEMS / 8;
  localparam int unsigned BUF_BYTES  = 2 * GROUP_ITEMS;
  localparam int unsigned CNT_W      = $clog2(BUF_BYTES + 1);
  localparam int unsigned BUF_AW     = $clog2(BUF_BYTES);
  localparam int unsigned ITEM_W     = $clog2(GROUP_ITEMS + 1);
  localparam int unsigned CTRL_AW    = $clog2(GROUP_ITEMS);

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] EMIT_CTRL = 2'd1;
  localparam logic [1:0] EMIT_DATA = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GROUP_ITEMS-1:0] ctrl_q, ctrl_d;
  logic [7:0]             data_buf_q [BUF_BYTES];
  logic [7:0]             data_buf_d [BUF_BYTES];
  logic [ITEM_W-1:0]      item_cnt_q, item_cnt_d;
  logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]       ptr_q, ptr_d;
  logic                   last_grp_q, last_grp_d;
  logic                   tok_ready_q, tok_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_byte_q, out_byte_d;
  logic                   out_last_q, out_last_d;
  logic                   packer_busy_q, packer_busy_d;

  logic                   accept;
  logic                   out_fire;
  logic [BUF_AW-1:0]      wr_idx;

  assign accept   = tok_valid && tok_ready_q && (state_q == FILL);
  assign out_fire = out_valid_q && out_ready;
  assign wr_idx   = BUF_AW'(byte_cnt_q);

  // Next-state, buffer fill and output byte selection.
  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    data_buf_d    = data_buf_q;
    item_cnt_d    = item_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    ptr_d         = ptr_q;
    last_grp_d    = last_grp_q;
    out_valid_d   = out_valid_q;
    out_byte_d    = out_byte_q;
    out_last_d    = out_last_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          ctrl_d[CTRL_AW'(item_cnt_q)] = tok_is_copy;
          if (tok_is_copy) begin
            data_buf_d[wr_idx]               = tok_data[15:8];
            data_buf_d[wr_idx + BUF_AW'(1)]  = tok_data[7:0];
            byte_cnt_d                       = byte_cnt_q + CNT_W'(2);
          end else begin
            data_buf_d[wr_idx] = tok_data[7:0];
            byte_cnt_d         = byte_cnt_q + CNT_W'(1);
          end
          item_cnt_d = item_cnt_q + ITEM_W'(1);
          if ((item_cnt_d == ITEM_W'(GROUP_ITEMS)) || tok_last) begin
            last_grp_d  = tok_last;
            state_d     = EMIT_CTRL;
            ptr_d       = '0;
            out_valid_d = 1'b1;
            out_byte_d  = ctrl_d[7:0];
            out_last_d  = 1'b0;
          end
        end
      end
      EMIT_CTRL: begin
        // Control word goes out LSB first by shifting it down one byte per handshake.
        if (out_fire) begin
          if (ptr_q == CNT_W'(CTRL_BYTES - 1)) begin
            state_d    = EMIT_DATA;
            ptr_d      = '0;
            out_byte_d = data_buf_q[0];
            out_last_d = last_grp_q && (byte_cnt_q == CNT_W'(1));
          end else begin
            ctrl_d     = ctrl_q >> 8;
            ptr_d      = ptr_q + CNT_W'(1);
            out_byte_d = ctrl_d[7:0];
          end
        end
      end
      EMIT_DATA: begin
        if (out_fire) begin
          if ((ptr_q + CNT_W'(1)) == byte_cnt_q) begin
            state_d     = FILL;
            ctrl_d      = '0;
            item_cnt_d  = '0;
            byte_cnt_d  = '0;
            last_grp_d  = 1'b0;
            ptr_d       = '0;
            out_valid_d = 1'b0;
            out_byte_d  = '0;
            out_last_d  = 1'b0;
          end else begin
            ptr_d      = ptr_q + CNT_W'(1);
            out_byte_d = data_buf_q[BUF_AW'(ptr_d)];
            out_last_d = last_grp_q && ((ptr_d + CNT_W'(1)) == byte_cnt_q);
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    tok_ready_d   = (state_d == FILL);
    packer_busy_d = (state_d != FILL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      ctrl_q        <= '0;
      item_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      ptr_q         <= '0;
      last_grp_q    <= 1'b0;
      tok_ready_q   <= 1'b1;
      out_valid_q   <= 1'b0;
      out_byte_q    <= '0;
      out_last_q    <= 1'b0;
      packer_busy_q <= 1'b0;
      for (int i = 0; i < int'(BUF_BYTES); i++) begin
        data_buf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      item_cnt_q    <= item_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      ptr_q         <= ptr_d;
      last_grp_q    <= last_grp_d;
      tok_ready_q   <= tok_ready_d;
      out_valid_q   <= out_valid_d;
      out_byte_q    <= out_byte_d;
      out_last_q    <= out_last_d;
      packer_busy_q <= packer_busy_d;
      data_buf_q    <= data_buf_d;
    end
  end

  assign tok_ready   = tok_ready_q;
  assign out_valid   = out_valid_q;
  assign out_byte    = out_byte_q;
  assign out_last    = out_last_q;
  assign packer_busy = packer_busy_q;

`ifdef LZRW1_PACK_STATS_EN
  logic [31:0] stat_items_q, stat_items_d;
  logic [31:0] stat_bytes_q, stat_bytes_d;

  // Free-running accept/handshake counters, wrapping modulo 2^32.
  always_comb begin
    stat_items_d = stat_items_q;
    stat_bytes_d = stat_bytes_q;
    if (accept) begin
      stat_items_d = stat_items_q + 32'd1;
    end
    if (out_fire) begin
      stat_bytes_d = stat_bytes_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_items_q <= '0;
      stat_bytes_q <= '0;
    end else begin
      stat_items_q <= stat_items_d;
      stat_bytes_q <= stat_bytes_d;
    end
  end

  assign stat_items = stat_items_q;
  assign stat_bytes = stat_bytes_q;
`else
  assign stat_items = '0;
  assign stat_bytes = '0;
`endif

endmodule
